// File: rtl/lib_uart.sv
// Shared UART definitions: transmitter state encoding and frame constants.
// Optional feature macro used by the transmitter: UART_TX_PARITY_EN.
package lib_uart;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  // Index of the final data bit; the bit counter wraps from here to 0.
  localparam logic [2:0] LAST_BIT_IDX = 3'(DATA_BITS - 1);

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time generator: a down-counter reloaded at every bit boundary.
// tick is high in the final cycle of a bit time (count at zero).
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic reload,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD_VAL = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  // Reload on a bit boundary, otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (reload) begin
      count <= RELOAD_VAL;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, 8 data bits LSB first, optional even
// parity bit, 1 stop bit. Define UART_TX_PARITY_EN to add the parity bit.
// A level request sends one frame; the request must be seen low while
// idle (or during the stop bit) before another frame is accepted.
// The state output exposes the FSM for observation.
module uart_tx
  import lib_uart::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tx_req,
  input  logic [7:0]     tx_data,
  output logic           tx_busy,
  output logic           txd,
  output uart_tx_state_t state
);

  logic       armed;
  logic [7:0] shreg;
  logic [2:0] bit_idx;
  logic       tick;
  logic       accept;
  logic       reload;
`ifdef UART_TX_PARITY_EN
  logic       parity;
`endif

  assign accept = (state == IDLE) && tx_req && armed;
  // Reload at acceptance and at every bit boundary inside a frame.
  assign reload = accept || ((state != IDLE) && tick);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk   (clk),
    .reset (reset),
    .reload(reload),
    .tick  (tick)
  );

  // Frame sequencer with registered line, busy and arming state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      txd     <= STOP_BIT;
      tx_busy <= 1'b0;
      armed   <= 1'b1;
      shreg   <= '0;
      bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      // Re-arm only when the request is seen low between frames.
      if (((state == IDLE) || (state == STOP)) && !tx_req) begin
        armed <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= START;
            shreg   <= tx_data;
            armed   <= 1'b0;
            tx_busy <= 1'b1;
            txd     <= START_BIT;
`ifdef UART_TX_PARITY_EN
            parity  <= ^tx_data;
`endif
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            txd   <= shreg[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == LAST_BIT_IDX) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              txd     <= parity;
`else
              state   <= STOP;
              txd     <= STOP_BIT;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              txd     <= shreg[1];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state <= STOP;
            txd   <= STOP_BIT;
          end
        end
        STOP: begin
          if (tick) begin
            state   <= IDLE;
            tx_busy <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4. Build with
// UART_TX_PARITY_EN defined to exercise the parity-bit frame format.
module tb_uart_tx;
  import lib_uart::*;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic           clk;
  logic           reset;
  logic           tx_req;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic           txd;
  uart_tx_state_t state;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .tx_req (tx_req),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .txd    (txd),
    .state  (state)
  );

  // Clock: 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks one whole frame starting at the next falling edge (first START
  // cycle), then the first cycle after the stop bit.
  task automatic frame_check(input logic [7:0] d, input string tag);
    logic [10:0] frame;
    frame    = '1;
    frame[0] = 1'b0;
    for (int i = 0; i < 8; i++) frame[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
    frame[9] = ^d;
`endif
    for (int b = 0; b < FRAME_BITS; b++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        check($sformatf("%s_txd_bit%0d", tag, b), 32'(txd), 32'(frame[b]));
        check($sformatf("%s_busy_bit%0d", tag, b), 32'(tx_busy), 32'd1);
      end
    end
    @(negedge clk);
    check({tag, "_busy_end"}, 32'(tx_busy), 32'd0);
    check({tag, "_txd_end"}, 32'(txd), 32'd1);
    check({tag, "_state_end"}, 32'(state), 32'(IDLE));
  endtask

  // One-cycle request pulse; returns in the first cycle after acceptance.
  task automatic pulse_req(input logic [7:0] d);
    @(posedge clk);
    #1 tx_req = 1'b1;
    tx_data = d;
    @(posedge clk);
    #1 tx_req = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    tx_req  = 1'b0;
    tx_data = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_state", 32'(state), 32'(IDLE));
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(tx_busy), 32'd0);

    // 0x55 with a one-cycle request; busy must not rise before acceptance
    @(posedge clk);
    #1 tx_req = 1'b1;
    tx_data = 8'h55;
    @(negedge clk);
    check("t1_pre_accept_busy", 32'(tx_busy), 32'd0);
    @(posedge clk);
    #1 tx_req = 1'b0;
    tx_data = 8'hFF;
    frame_check(8'h55, "t1");

    // Held request gives exactly one frame
    @(posedge clk);
    #1 tx_req = 1'b1;
    tx_data = 8'hA3;
    @(posedge clk);
    #1 tx_data = 8'h5C;
    frame_check(8'hA3, "t2");
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      check("t2_held_busy", 32'(tx_busy), 32'd0);
    end
    check("t2_held_txd", 32'(txd), 32'd1);
    @(posedge clk);
    #1 tx_req = 1'b0;
    repeat (2) @(posedge clk);

    // Re-request during the stop bit: back-to-back frame one cycle after busy falls
    @(posedge clk);
    #1 tx_req = 1'b1;
    tx_data = 8'h01;
    @(posedge clk);
    #1;
    fork
      begin
        frame_check(8'h01, "t3a");
        frame_check(8'h02, "t3b");
      end
      begin
        repeat ((FRAME_BITS - 1) * CPB + 1) @(posedge clk);
        #1 tx_req = 1'b0;
        tx_data = 8'h02;
        @(posedge clk);
        #1 tx_req = 1'b1;
      end
    join
    @(posedge clk);
    #1 tx_req = 1'b0;
    repeat (2) @(negedge clk);
    check("t3_after_busy", 32'(tx_busy), 32'd0);

    // Asynchronous reset during data bit 3 (0xC5 has bit 3 = 0)
    pulse_req(8'hC5);
    repeat (18) @(negedge clk);
    check("t4_pre_txd", 32'(txd), 32'd0);
    check("t4_pre_busy", 32'(tx_busy), 32'd1);
    check("t4_pre_state", 32'(state), 32'(DATA));
    #2 reset = 1'b0;
    #1;
    check("t4_async_txd", 32'(txd), 32'd1);
    check("t4_async_busy", 32'(tx_busy), 32'd0);
    check("t4_async_state", 32'(state), 32'(IDLE));
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_release_busy", 32'(tx_busy), 32'd0);
    check("t4_release_txd", 32'(txd), 32'd1);
    pulse_req(8'h3C);
    frame_check(8'h3C, "t4_next");

    // Odd and even parity data (parity bit present only in parity builds)
    pulse_req(8'h07);
    frame_check(8'h07, "t5_07");
    pulse_req(8'h03);
    frame_check(8'h03, "t5_03");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  single clock; all sequential logic on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port tx_req  input  1  level request from the CPU; a frame is requested while high.
REQ-005 SHALL have port tx_data  input  8  byte to send; sampled only on frame acceptance.
REQ-006 SHALL have port tx_busy  output  1  high from acceptance until the stop bit completes.
REQ-007 SHALL have port txd  output  1  serial line; idle level is high.

Function
REQ-008 SHALL frame each byte as 1 start bit (0), 8 data bits LSB first, optional parity bit (REQ-019), then 1 stop bit (1).
REQ-009 SHALL hold every bit on txd for exactly CLKS_PER_BIT clk cycles.
REQ-010 SHALL use states IDLE, START, DATA, PARITY, STOP; transitions: IDLE->START on accept; START->DATA after one bit time; DATA->DATA for bits 0..6; DATA->PARITY or STOP after bit 7; PARITY->STOP; STOP->IDLE after one bit time.
REQ-011 SHALL accept a frame in the cycle where state is IDLE, tx_req is high and the armed flag is set; on acceptance it latches tx_data into a shift register and clears armed.
REQ-012 SHALL set armed whenever tx_req is sampled low and state is IDLE or STOP, so a continuously held tx_req produces exactly one frame.
REQ-013 SHALL assert tx_busy and drive txd low in the first cycle after acceptance (one-cycle latency).
REQ-014 SHALL deassert tx_busy in the first cycle after the last stop-bit cycle, in the same cycle state returns to IDLE.
REQ-015 SHALL ignore tx_req and tx_data changes while busy; no queuing of a request made during a frame, except through armed per REQ-012.
REQ-016 SHALL accept a new frame in the first IDLE cycle after STOP if tx_req is high and armed, giving back-to-back frames with no idle gap beyond one cycle.
REQ-017 SHALL implement the bit-time counter as a down-counter of width ceil(log2(CLKS_PER_BIT)) that reloads CLKS_PER_BIT-1 on every bit boundary and never wraps past zero; the data-bit index SHALL be a 3-bit counter wrapping 7->0 only on exit from DATA.

Reset
REQ-018 SHALL on reset low, regardless of clk, force state IDLE, txd 1, tx_busy 0, armed 1, counters and shift register 0; reset asserted mid-frame aborts the frame and leaves txd high; no frame starts in the first cycle after reset release unless tx_req is high (armed is already 1).

Configuration
REQ-019 SHALL, with macro UART_TX_PARITY_EN defined, insert a PARITY state sending the even-parity bit (XOR of the 8 data bits) between bit 7 and stop, frame length 11 bit times; without it, PARITY is unreachable, frame length 10 bit times.

Structure
REQ-020 SHALL place the state enum (UART_TX_STATE) and the frame constants (START_BIT=0, STOP_BIT=1, DATA_BITS=8) in shared package lib_uart.
REQ-021 SHALL implement bit timing in sub-module uart_baud_gen (reload/count/tick output), instantiated once.

Verification
REQ-022 SHALL cover: CLKS_PER_BIT=4, tx_req pulse 1 cycle, tx_data=8'h55 -> txd 0,1,0,1,0,1,0,1,0,1 each for 4 cycles, tx_busy high 40 cycles.
REQ-023 SHALL cover: tx_req held high 200 cycles, tx_data=8'hA3, CLKS_PER_BIT=4 -> exactly one frame, tx_busy then stays low.
REQ-024 SHALL cover: tx_req toggled low then high during frame for 8'h01 -> second frame 8'h02 (data at re-request) starts one cycle after first tx_busy falls.
REQ-025 SHALL cover: reset low at data bit 3 -> txd 1 and tx_busy 0 asynchronously; next request sends a complete frame.
REQ-026 SHALL cover: UART_TX_PARITY_EN defined, tx_data=8'h07 -> parity bit 1, frame 11 bit times; 8'h03 -> parity bit 0.
